booth_mul_sched: RTL and testbench



---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_mul_sched_rr_arbiter.sv | 32 +++
 rtl/booth_mul_sched.sv | 139 +++++++++++++
 tb/tb_booth_mul_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the time-shared Booth multiplier: FSM states, Booth pair codes
// and width helpers for the requester id and step counter fields.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/booth_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request above ptr, with wrap.
// Zero latency; grants nothing when no request is asserted.
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [id_width(N)-1:0] ptr,
  output logic [N-1:0]           grant,
  output logic [id_width(N)-1:0] idx
);

  localparam int IW = id_width(N);

  logic found;

  // Search order is ptr+1, ptr+2, ... ptr, so the last winner ranks lowest.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                        = 1'b1;
        grant[(int'(ptr) + k) % N]   = 1'b1;
        idx                          = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Radix-2 Booth multiplier shared by NUM_REQ requesters; product valid WIDTH clocks after accept.
// Requests are only granted in IDLE; the product is held in DONE until rsp_ready.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]         rsp_result,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    cur_id;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc;
  logic             q_1;
  logic [CW-1:0]    cnt;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH:0]     b_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_nxt;
  logic [WIDTH-1:0]   a_nxt;
  logic               last;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = (state == IDLE) ? grant : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // One extra accumulator bit keeps -b representable when b is the most negative value.
  assign b_ext = {b_q[WIDTH-1], b_q};

  always_comb begin
    sum = acc;
    unique case ({a_q[0], q_1})
      BOOTH_ADD:  sum = acc + b_ext;
      BOOTH_SUB:  sum = acc - b_ext;
      BOOTH_NOP0: sum = acc;
      BOOTH_NOP1: sum = acc;
    endcase
  end

  assign acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
  assign a_nxt   = {sum[0], a_q[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IW'(NUM_REQ - 1);
      cur_id     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      q_1        <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_ready) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            cur_id <= grant_idx;
            ptr    <= grant_idx;
            acc    <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          a_q <= a_nxt;
          q_1 <= a_q[0];
          cnt <= cnt + 1'b1;
          if (last) begin
            state      <= DONE;
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= {acc_nxt[WIDTH-1:0], a_nxt};
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: accepted requests push a reference product,
// completed responses pop and compare; directed scenarios check timing and arbitration.
module tb_booth_mul_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [2*W-1:0]   rsp_result;
  logic             busy;

  booth_mul_sched #(
    .NUM_REQ(N),
    .WIDTH  (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [2*W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   accept_cyc[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so at negedge they show what the next edge samples.
  logic signed [W-1:0]   m_a, m_b;
  logic signed [2*W-1:0] m_p;
  exp_t                  m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) check("ready_while_busy", 32'(req_ready), 32'd0);
      if (!$onehot0(req_ready)) check("ready_onehot", 32'(req_ready), 32'd0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          m_a = req_a[i*W +: W];
          m_b = req_b[i*W +: W];
          m_p = m_a * m_b;
          sb.push_back('{id: IW'(i), res: m_p});
          grant_log.push_back(i);
          accept_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_result), 32'hdead);
        end else begin
          m_e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(m_e.id));
          check("rsp_result", 32'(rsp_result), 32'(m_e.res));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic hold_until_granted(input int i);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1;
    end
    if (!got) check("grant_timeout", 32'(i), 32'hffff);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    @(posedge clk);
    #1;
    set_req(i, a, b);
    hold_until_granted(i);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && sb.size() == 0) ok = 1;
    end
    if (!ok) check("idle_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_grants(input int n);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (grant_log.size() >= n) ok = 1;
    end
    if (!ok) check("grants_timeout", 32'(grant_log.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    grant_log.delete();
    accept_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0]  hold_id;
    logic [2*W-1:0] hold_res;
    logic signed [W-1:0] ra, rb;
    int lat;
    int gap;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic multiply and latency
    issue(0, 8'sd3, -8'sd5);
    lat = -1;
    for (int k = 1; k <= W + 4 && lat < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) lat = k - 1;
    end
    check("basic_latency", 32'(lat), 32'(W));
    check("basic_id", 32'(rsp_id), 32'd0);
    check("basic_result", 32'(rsp_result), 32'h0000fff1);
    wait_idle();

    // Corner operands
    issue(1, -8'sd128, -8'sd128);
    issue(2, -8'sd128, 8'sd127);
    issue(3, 8'sd0, -8'sd1);
    issue(0, 8'sd127, 8'sd127);
    issue(1, 8'sd127, -8'sd128);
    wait_idle();

    // Random sweep over all sign quadrants
    for (int k = 0; k < 16; k++) begin
      ra = 8'($urandom_range(1, 127));
      rb = 8'($urandom_range(1, 127));
      if (k[0]) ra = -ra;
      if (k[1]) rb = -rb;
      issue(int'($urandom_range(0, N - 1)), ra, rb);
    end
    wait_idle();

    // Four-way contention from reset
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 37 - 60), 8'(45 - i * 29));
    do_reset();
    wait_grants(5);
    req_valid = '0;
    check("rr_grant0", 32'(grant_log[0]), 32'd0);
    check("rr_grant1", 32'(grant_log[1]), 32'd1);
    check("rr_grant2", 32'(grant_log[2]), 32'd2);
    check("rr_grant3", 32'(grant_log[3]), 32'd3);
    check("rr_grant4", 32'(grant_log[4]), 32'd0);
    wait_idle();

    // Response backpressure with req1 pending
    rsp_ready = 1'b0;
    issue(0, -8'sd77, 8'sd91);
    set_req(1, 8'sd19, -8'sd33);
    for (int k = 0; k < 30 && !rsp_valid; k++) @(negedge clk);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    hold_id  = rsp_id;
    hold_res = rsp_result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id", 32'(rsp_id), 32'(hold_id));
      check("bp_hold_result", 32'(rsp_result), 32'(hold_res));
      check("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    gap = -1;
    for (int k = 1; k <= 6 && gap < 0; k++) begin
      @(negedge clk);
      if (req_ready[1]) gap = k;
    end
    check("bp_regrant_edges", 32'(gap), 32'd2);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_idle();

    // Reset in the fourth RUN cycle
    issue(3, 8'sd5, 8'sd6);
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(busy), 32'd1);
    set_req(2, 8'sd11, 8'sd12);
    set_req(0, -8'sd13, 8'sd14);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    do_reset();
    wait_grants(1);
    req_valid[0] = 1'b0;
    check("abort_first_grant", 32'(grant_log[0]), 32'd0);
    wait_grants(2);
    req_valid[2] = 1'b0;
    check("abort_second_grant", 32'(grant_log[1]), 32'd2);
    wait_idle();

    // Sparse: req3 alone three times, then req1 joins mid-run
    grant_log.delete();
    accept_cyc.delete();
    @(posedge clk);
    #1;
    set_req(3, -8'sd99, 8'sd3);
    wait_grants(3);
    set_req(1, 8'sd42, -8'sd42);
    wait_grants(4);
    req_valid = '0;
    check("sparse_gap1", 32'(accept_cyc[1] - accept_cyc[0]), 32'(W + 2));
    check("sparse_gap2", 32'(accept_cyc[2] - accept_cyc[1]), 32'(W + 2));
    check("sparse_ids", 32'({grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0]}), 32'h333);
    check("sparse_req1_wins", 32'(grant_log[3]), 32'd1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
